// File: rtl/ddr3_test_monitor_axil_pkg.sv
// Shared types and address decode for the DDR3 test monitor AXI4-Lite register block.
// Status decode depends on DDR3_TEST_MONITOR_STATUS_EN.
package ddr3_test_monitor_axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    localparam int REG_CTRL    = 0;
    localparam int REG_1       = 1;
    localparam int REG_2       = 2;
    localparam int REG_3       = 3;
    localparam int NUM_RW_REGS = 4;

    localparam logic [31:0] STATUS_ID = 32'hDD30_0001;

    typedef struct packed {
        logic       rw_hit;
        logic       status_hit;
        logic [1:0] idx;
    } decode_t;

    // Word select is byte address bits [4:2]; words 0-3 are RW, 4-7 are the status page.
    function automatic decode_t decode_addr(input logic [2:0] word_sel);
        decode_t d;
        d.idx    = word_sel[1:0];
        d.rw_hit = !word_sel[2];
`ifdef DDR3_TEST_MONITOR_STATUS_EN
        d.status_hit = word_sel[2];
`else
        d.status_hit = 1'b0;
`endif
        return d;
    endfunction

endpackage

// File: rtl/ddr3_test_monitor_axil_slave.sv
// AXI4-Lite responder holding four RW control registers for the DDR3 test monitor.
// Define DDR3_TEST_MONITOR_STATUS_EN to add the read-only status words at 0x10-0x1C.
module ddr3_test_monitor_axil_slave
    import ddr3_test_monitor_axil_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] RESET_VALUE        = 32'h0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     o_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     o_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     o_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     o_reg3,
    output logic [NUM_RW_REGS-1:0]            o_wr_pulse,
    input  logic [31:0]                       i_err_count,
    input  logic [31:0]                       i_pass_count
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    logic [DW-1:0]          regs [NUM_RW_REGS];
    logic                   aw_held, w_held;
    logic [2:0]             aw_sel_q;
    logic [DW-1:0]          w_data_q;
    logic [SW-1:0]          w_strb_q;
    logic                   bvalid_q, rvalid_q;
    resp_t                  bresp_q, rresp_q;
    logic [DW-1:0]          rdata_q;
    logic [NUM_RW_REGS-1:0] wr_pulse_q;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [2:0]    wr_sel;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    decode_t       wr_dec, rd_dec;
    logic [DW-1:0] rd_word;
    resp_t         rd_resp;

    // Readies are forced low while reset is held so nothing handshakes during reset.
    assign s_axi_awready = !i_rst && !aw_held && !bvalid_q;
    assign s_axi_wready  = !i_rst && !w_held && !bvalid_q;
    assign s_axi_arready = !i_rst && !rvalid_q;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid_q;

    assign wr_sel  = aw_held ? aw_sel_q : s_axi_awaddr[4:2];
    assign wr_data = w_held ? w_data_q : s_axi_wdata;
    assign wr_strb = w_held ? w_strb_q : s_axi_wstrb;
    assign wr_dec  = decode_addr(wr_sel);
    assign rd_dec  = decode_addr(s_axi_araddr[4:2]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            aw_held  <= 1'b0;
            aw_sel_q <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
        end else if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_sel_q <= s_axi_awaddr[4:2];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            w_held <= 1'b0;
        end else if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
        end
    end

    // NOTE: the register file is only four words of flops, so it is reset like any other state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_RW_REGS; r++) regs[r] <= RESET_VALUE;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (commit) begin
                bvalid_q <= 1'b1;
                if (wr_dec.rw_hit) begin
                    bresp_q <= RESP_OKAY;
                    for (int b = 0; b < SW; b++)
                        if (wr_strb[b]) regs[wr_dec.idx][8*b +: 8] <= wr_data[8*b +: 8];
                    if (|wr_strb) wr_pulse_q[wr_dec.idx] <= 1'b1;
                end else begin
                    bresp_q <= RESP_SLVERR;
                end
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

`ifdef DDR3_TEST_MONITOR_STATUS_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_word = '0;
        rd_resp = RESP_SLVERR;
        if (rd_dec.rw_hit) begin
            rd_word = regs[rd_dec.idx];
            rd_resp = RESP_OKAY;
        end
`ifdef DDR3_TEST_MONITOR_STATUS_EN
        else if (rd_dec.status_hit) begin
            rd_resp = RESP_OKAY;
            case (rd_dec.idx)
                2'd0:    rd_word = i_err_count;
                2'd1:    rd_word = i_pass_count;
                2'd2:    rd_word = cycle_cnt;
                default: rd_word = STATUS_ID;
            endcase
        end
`endif
    end

    // The read captures the register before any same-edge write lands.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp;
            rdata_q  <= rd_word;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;
    assign o_wr_pulse   = wr_pulse_q;
    assign o_reg0       = regs[REG_CTRL];
    assign o_reg1       = regs[REG_1];
    assign o_reg2       = regs[REG_2];
    assign o_reg3       = regs[REG_3];

    logic unused_inputs;
`ifdef DDR3_TEST_MONITOR_STATUS_EN
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                             i_err_count, i_pass_count};
`endif

endmodule

// File: tb/tb_ddr3_test_monitor_axil_slave.sv
// Directed self-checking bench for ddr3_test_monitor_axil_slave (default build, status page off).
module tb_ddr3_test_monitor_axil_slave;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [4:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] o_reg0, o_reg1, o_reg2, o_reg3;
    logic [3:0]  o_wr_pulse;
    logic [31:0] i_err_count;
    logic [31:0] i_pass_count;

    int checks = 0;
    int errors = 0;
    int pulse_cnt [4];

    always #5 i_clk = ~i_clk;

    ddr3_test_monitor_axil_slave dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awprot (s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arprot (s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .o_reg0       (o_reg0),
        .o_reg1       (o_reg1),
        .o_reg2       (o_reg2),
        .o_reg3       (o_reg3),
        .o_wr_pulse   (o_wr_pulse),
        .i_err_count  (i_err_count),
        .i_pass_count (i_pass_count)
    );

    // Pulses last one full cycle, so counting at the falling edge sees each exactly once.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            for (int p = 0; p < 4; p++) pulse_cnt[p] += int'(o_wr_pulse[p]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_done, w_done;
        int   n;
        resp = 2'bxx;
        @(negedge i_clk);
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            #1;
            if (s_axi_awvalid && s_axi_awready) aw_done = 1'b1;
            if (s_axi_wvalid && s_axi_wready)   w_done  = 1'b1;
            @(negedge i_clk);
            if (aw_done) s_axi_awvalid = 1'b0;
            if (w_done)  s_axi_wvalid  = 1'b0;
            n++;
        end
        check("write_addr_data_accepted", {30'd0, aw_done, w_done}, 32'd3);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("write_bvalid_seen", s_axi_bvalid, 1);
        resp = s_axi_bresp;
        @(negedge i_clk);
        s_axi_bready = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] data, output logic [1:0] resp);
        logic done;
        int   n;
        @(negedge i_clk);
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        done = 1'b0; n = 0;
        while (!done && n < 20) begin
            #1;
            if (s_axi_arready) done = 1'b1;
            @(negedge i_clk);
            if (done) s_axi_arvalid = 1'b0;
            n++;
        end
        check("read_addr_accepted", done, 1);
        n = 0;
        while (!s_axi_rvalid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("read_rvalid_seen", s_axi_rvalid, 1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        @(negedge i_clk);
        s_axi_rready = 1'b0;
        s_axi_arvalid = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] exp_reg [4];

        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        i_rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        i_err_count = 32'h0000_00E1; i_pass_count = 32'h0000_0FA5;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        check("rst_wr_pulse", o_wr_pulse, 0);
        check("rst_reg0", o_reg0, 32'h0);
        check("rst_reg3", o_reg3, 32'h0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("post_rst_awready", s_axi_awready, 1);
        check("post_rst_wready", s_axi_wready, 1);
        check("post_rst_arready", s_axi_arready, 1);

        // Sequential RW
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, resp);
            check($sformatf("seq_bresp_%0d", i), resp, 2'b00);
            exp_reg[i] = 32'(i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), data, resp);
            check($sformatf("seq_rdata_%0d", i), data, exp_reg[i]);
            check($sformatf("seq_rresp_%0d", i), resp, 2'b00);
            check($sformatf("seq_pulse_%0d", i), pulse_cnt[i], 1);
        end

        // Partial strobe over 0x11223344
        axi_write(5'h04, 32'h1122_3344, 4'hF, resp);
        axi_write(5'h04, 32'hAABB_CCDD, 4'b0101, resp);
        check("strb_bresp", resp, 2'b00);
        axi_read(5'h04, data, resp);
        check("strb_rdata", data, 32'h11BB_33DD);
        exp_reg[1] = 32'h11BB_33DD;

        // Skewed: W three cycles ahead of AW, bready low for five cycles
        @(negedge i_clk);
        s_axi_wdata = 32'h0000_0055; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        #1 check("skew1_wready", s_axi_wready, 1);
        @(negedge i_clk);
        s_axi_wvalid = 1'b0;
        check("skew1_w_held_wready", s_axi_wready, 0);
        check("skew1_no_early_bvalid", s_axi_bvalid, 0);
        repeat (2) @(negedge i_clk);
        s_axi_awaddr = 5'h0C; s_axi_awvalid = 1'b1;
        #1 check("skew1_awready", s_axi_awready, 1);
        @(negedge i_clk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("skew1_bvalid_hold", s_axi_bvalid, 1);
            check("skew1_bresp_hold", s_axi_bresp, 2'b00);
            check("skew1_ready_low", {s_axi_awready, s_axi_wready}, 2'b00);
            @(negedge i_clk);
        end
        s_axi_bready = 1'b1;
        @(negedge i_clk);
        s_axi_bready = 1'b0;
        check("skew1_bvalid_drop", s_axi_bvalid, 0);
        check("skew1_reg3", o_reg3, 32'h0000_0055);
        exp_reg[3] = 32'h0000_0055;

        // Skewed: AW three cycles ahead of W
        s_axi_awaddr = 5'h00; s_axi_awvalid = 1'b1;
        #1 check("skew2_awready", s_axi_awready, 1);
        @(negedge i_clk);
        s_axi_awvalid = 1'b0;
        check("skew2_aw_held_awready", s_axi_awready, 0);
        repeat (2) @(negedge i_clk);
        s_axi_wdata = 32'h0000_0066; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        #1 check("skew2_wready", s_axi_wready, 1);
        @(negedge i_clk);
        s_axi_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("skew2_bvalid_hold", s_axi_bvalid, 1);
            check("skew2_ready_low", {s_axi_awready, s_axi_wready}, 2'b00);
            @(negedge i_clk);
        end
        s_axi_bready = 1'b1;
        @(negedge i_clk);
        s_axi_bready = 1'b0;
        check("skew2_bvalid_drop", s_axi_bvalid, 0);
        axi_read(5'h00, data, resp);
        check("skew2_rdata", data, 32'h0000_0066);
        exp_reg[0] = 32'h0000_0066;

        // Out-of-range 0x14
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, resp);
        check("oor_bresp", resp, 2'b10);
        axi_read(5'h14, data, resp);
        check("oor_rresp", resp, 2'b10);
        check("oor_rdata", data, 32'h0);
        check("oor_reg0", o_reg0, exp_reg[0]);
        check("oor_reg1", o_reg1, exp_reg[1]);
        check("oor_reg2", o_reg2, exp_reg[2]);
        check("oor_reg3", o_reg3, exp_reg[3]);

        // Same-cycle read and write of 0x8
        axi_write(5'h08, 32'd5, 4'hF, resp);
        @(negedge i_clk);
        s_axi_araddr = 5'h08; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        s_axi_awaddr = 5'h08; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'd9; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        #1 check("coll_all_ready", {s_axi_arready, s_axi_awready, s_axi_wready}, 3'b111);
        @(negedge i_clk);
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("coll_rvalid", s_axi_rvalid, 1);
        check("coll_rdata_old", s_axi_rdata, 32'd5);
        check("coll_bvalid", s_axi_bvalid, 1);
        check("coll_reg2_new", o_reg2, 32'd9);
        @(negedge i_clk);
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        axi_read(5'h08, data, resp);
        check("coll_rdata_new", data, 32'd9);

        // Reset after AW handshake, before W
        @(negedge i_clk);
        s_axi_awaddr = 5'h00; s_axi_awvalid = 1'b1; s_axi_bready = 1'b1;
        #1 check("rstmid_awready", s_axi_awready, 1);
        @(negedge i_clk);
        s_axi_awvalid = 1'b0;
        check("rstmid_aw_held", s_axi_awready, 0);
        i_rst = 1'b1;
        #1;
        check("rstmid_reg0", o_reg0, 32'h0);
        check("rstmid_reg1", o_reg1, 32'h0);
        check("rstmid_reg2", o_reg2, 32'h0);
        check("rstmid_reg3", o_reg3, 32'h0);
        repeat (2) begin
            @(negedge i_clk);
            check("rstmid_bvalid_in_rst", s_axi_bvalid, 0);
        end
        i_rst = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            check("rstmid_bvalid_after", s_axi_bvalid, 0);
            check("rstmid_awready_after", s_axi_awready, 1);
        end
        s_axi_bready = 1'b0;
        axi_write(5'h04, 32'h0000_0077, 4'hF, resp);
        check("rstmid_new_bresp", resp, 2'b00);
        axi_read(5'h04, data, resp);
        check("rstmid_new_rdata", data, 32'h0000_0077);
        check("rstmid_reg0_untouched", o_reg0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
